// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the 128-word data memory: IDLE -> ACCESS -> DONE, one access per grant.
// Define DM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester A wins every tie.
module dm_arbiter #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Req_A,
  input  logic          Write_A,
  input  logic [AW-1:0] Addr_A,
  input  logic [DW-1:0] WData_A,
  output logic          Gnt_A,
  output logic          Done_A,
  output logic [DW-1:0] RData_A,
  input  logic          Req_B,
  input  logic          Write_B,
  input  logic [AW-1:0] Addr_B,
  input  logic [DW-1:0] WData_B,
  output logic          Gnt_B,
  output logic          Done_B,
  output logic [DW-1:0] RData_B,
  output logic          DM_Write,
  output logic [AW-1:0] DM_Addr,
  output logic [DW-1:0] DM_Data_In,
  input  logic [DW-1:0] DM_Data_Out,
  output logic          Busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;        // 0 = A, 1 = B
  logic            cmd_write_q, cmd_write_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]   cmd_data_q, cmd_data_d;
  logic            gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic            done_a_q, done_a_d, done_b_q, done_b_d;
  logic [DW-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic [15:0]     access_count_q, access_count_d;
  logic            pick_b;
`ifdef DM_ARB_ROUND_ROBIN_EN
  logic            last_owner_q, last_owner_d;
`endif

  // Next-state, arbitration and command-latch logic.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    cmd_write_d    = cmd_write_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_data_d     = cmd_data_q;
    gnt_a_d        = 1'b0;
    gnt_b_d        = 1'b0;
    done_a_d       = 1'b0;
    done_b_d       = 1'b0;
    rdata_a_d      = rdata_a_q;
    rdata_b_d      = rdata_b_q;
    access_count_d = access_count_q;
    pick_b         = 1'b0;
`ifdef DM_ARB_ROUND_ROBIN_EN
    last_owner_d   = last_owner_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Req_A && Req_B) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
          pick_b = ~last_owner_q;
`else
          pick_b = 1'b0;
`endif
        end else if (Req_B) begin
          pick_b = 1'b1;
        end else begin
          pick_b = 1'b0;
        end
        if (Req_A || Req_B) begin
          owner_d     = pick_b;
          cmd_write_d = pick_b ? Write_B : Write_A;
          cmd_addr_d  = pick_b ? Addr_B  : Addr_A;
          cmd_data_d  = pick_b ? WData_B : WData_A;
          gnt_a_d     = ~pick_b;
          gnt_b_d     = pick_b;
          state_d     = S_ACCESS;
`ifdef DM_ARB_ROUND_ROBIN_EN
          last_owner_d = pick_b;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (!cmd_write_q) begin
          if (owner_q) begin
            rdata_b_d = DM_Data_Out;
          end else begin
            rdata_a_d = DM_Data_Out;
          end
        end else begin
          rdata_a_d = rdata_a_q;
        end
        done_a_d       = ~owner_q;
        done_b_d       = owner_q;
        access_count_d = access_count_q + 16'd1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      owner_q        <= 1'b0;
      cmd_write_q    <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_data_q     <= '0;
      gnt_a_q        <= 1'b0;
      gnt_b_q        <= 1'b0;
      done_a_q       <= 1'b0;
      done_b_q       <= 1'b0;
      rdata_a_q      <= '0;
      rdata_b_q      <= '0;
      access_count_q <= 16'd0;
`ifdef DM_ARB_ROUND_ROBIN_EN
      last_owner_q   <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      cmd_write_q    <= cmd_write_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_data_q     <= cmd_data_d;
      gnt_a_q        <= gnt_a_d;
      gnt_b_q        <= gnt_b_d;
      done_a_q       <= done_a_d;
      done_b_q       <= done_b_d;
      rdata_a_q      <= rdata_a_d;
      rdata_b_q      <= rdata_b_d;
      access_count_q <= access_count_d;
`ifdef DM_ARB_ROUND_ROBIN_EN
      last_owner_q   <= last_owner_d;
`endif
    end
  end

  // rst gates the write combinationally so a reset in ACCESS never commits a store.
  assign DM_Write   = cmd_write_q & (state_q == S_ACCESS) & ~rst;
  assign DM_Addr    = cmd_addr_q;
  assign DM_Data_In = cmd_data_q;
  assign Busy       = (state_q != S_IDLE);
  assign Gnt_A      = gnt_a_q;
  assign Gnt_B      = gnt_b_q;
  assign Done_A     = done_a_q;
  assign Done_B     = done_b_q;
  assign RData_A    = rdata_a_q;
  assign RData_B    = rdata_b_q;

endmodule
